// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings and FSM states.
// No ports; imported by alu_multicycle.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
    localparam logic [OP_W-1:0] OP_XOR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_NOR   = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLTU  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLL   = 4'b1001;
    localparam logic [OP_W-1:0] OP_SRL   = 4'b1010;
    localparam logic [OP_W-1:0] OP_SRA   = 4'b1011;
    localparam logic [OP_W-1:0] OP_MULTU = 4'b1100;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one step per cycle.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   go         : load operands and start WIDTH steps
//   is_div     : 1 = divide a/b, 0 = multiply a*b (sampled with go)
//   a, b       : operands (sampled with go)
//   busy       : steps remain
//   fin        : the step being taken this cycle is the last one
//   hi, lo     : value the accumulator takes after this cycle's step
//                (product halves, or remainder/quotient); valid when fin=1
module alu_iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    // acc holds {product_hi, multiplier} for MUL or {remainder, dividend/quotient} for DIV
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_n;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      cnt;
    logic               mode;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    // Single step of the selected algorithm
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_part = acc[2*WIDTH-1:WIDTH-1];
        // Remainder stays below the divisor, so the true difference fits in WIDTH bits
        div_diff = div_part[WIDTH-1:0] - opnd;
        div_ge   = (div_part >= {1'b0, opnd});
        if (mode) begin
            acc_n = {(div_ge ? div_diff : div_part[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        end else begin
            acc_n = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    assign busy = (cnt != '0);
    assign fin  = (cnt == CW'(1));
    assign hi   = acc_n[2*WIDTH-1:WIDTH];
    assign lo   = acc_n[WIDTH-1:0];

    // Operand load and iteration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            opnd <= '0;
            cnt  <= '0;
            mode <= 1'b0;
        end else if (go) begin
            acc  <= {{WIDTH{1'b0}}, (is_div ? a : b)};
            opnd <= is_div ? b : a;
            cnt  <= CW'(WIDTH);
            mode <= is_div;
        end else if (busy) begin
            acc  <= acc_n;
            cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU with start/ready/done handshake.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start        : request, accepted only while ready=1
//   alu_control  : opcode; a, b : operands (all sampled on accept)
//   ready        : high only in IDLE (combinational from state)
//   done         : one-cycle pulse, results valid from this cycle
//   alu_out      : result (LO for MULTU/DIVU); hi_out : MULTU high / DIVU remainder
//   zout, ovf, div_by_zero, illegal : flags registered with alu_out
module alu_multicycle #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             zout,
    output logic             ovf,
    output logic             div_by_zero,
    output logic             illegal
);

    import alu_pkg::*;

    state_t           state;
    state_t           state_n;
    logic             go;
    logic             load_single;
    logic             load_md;
    logic             is_div;
    logic             dbz_q;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             ovf_c;
    logic             ill_c;

    logic             md_busy;
    logic             md_fin;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign is_div = (alu_control == OP_DIVU);
    assign ready  = (state == S_IDLE);

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .is_div (is_div),
        .a      (a),
        .b      (b),
        .busy   (md_busy),
        .fin    (md_fin),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    // Single-cycle operations
    always_comb begin
        sum   = a + b;
        diff  = a - b;
        shamt = b[SHW-1:0];
        res   = '0;
        ovf_c = 1'b0;
        ill_c = 1'b0;
        case (alu_control)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_ADD: begin
                res   = sum;
                ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff;
                ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: res = WIDTH'(a < b);
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = WIDTH'($signed(a) >>> shamt);
            OP_MULTU, OP_DIVU: res = '0;
            default: ill_c = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and load strobes
    always_comb begin
        state_n     = state;
        go          = 1'b0;
        load_single = 1'b0;
        load_md     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (alu_control == OP_MULTU) begin
                        go      = 1'b1;
                        state_n = S_MUL;
                    end else if (is_div) begin
                        go      = 1'b1;
                        state_n = S_DIV;
                    end else begin
                        load_single = 1'b1;
                        state_n     = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (md_fin) begin
                    load_md = 1'b1;
                    state_n = S_DONE;
                end else if (!md_busy) begin
                    // Engine idle without finishing: recover rather than hang
                    state_n = S_IDLE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Result and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done        <= 1'b0;
            dbz_q       <= 1'b0;
            alu_out     <= '0;
            hi_out      <= '0;
            zout        <= 1'b1;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            done <= (state_n == S_DONE);
            if (go) begin
                dbz_q <= is_div && (b == '0);
            end
            if (load_single) begin
                alu_out     <= res;
                hi_out      <= '0;
                zout        <= (res == '0);
                ovf         <= ovf_c;
                div_by_zero <= 1'b0;
                illegal     <= ill_c;
            end else if (load_md) begin
                alu_out     <= md_lo;
                hi_out      <= md_hi;
                zout        <= (md_lo == '0);
                ovf         <= 1'b0;
                div_by_zero <= dbz_q;
                illegal     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_multicycle;

    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   alu_control;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] alu_out;
    logic [W-1:0] hi_out;
    logic         zout;
    logic         ovf;
    logic         div_by_zero;
    logic         illegal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z;
        logic         ov;
        logic         dz;
        logic         il;
    } res_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        res_t         exp;
    } vec_t;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .done        (done),
        .alu_out     (alu_out),
        .hi_out      (hi_out),
        .zout        (zout),
        .ovf         (ovf),
        .div_by_zero (div_by_zero),
        .illegal     (illegal)
    );

    function automatic res_t mk(input logic [W-1:0] lo, input logic [W-1:0] hi,
                                input logic z, input logic ov, input logic dz, input logic il);
        res_t r;
        r.lo = lo; r.hi = hi; r.z = z; r.ov = ov; r.dz = dz; r.il = il;
        return r;
    endfunction

    // Reference model from the opcode table, using wide integer arithmetic
    function automatic res_t model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        res_t        r;
        longint      sa;
        longint      sb;
        longint      wide;
        logic [63:0] prod;
        int          sh;
        r  = '0;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        sh = int'(bv % 32);
        case (op)
            4'd0:  r.lo = av & bv;
            4'd1:  r.lo = av | bv;
            4'd2:  begin wide = sa + sb; r.lo = av + bv; r.ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            4'd3:  r.lo = av ^ bv;
            4'd5:  r.lo = ~(av | bv);
            4'd6:  begin wide = sa - sb; r.lo = av - bv; r.ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            4'd7:  r.lo = (sa < sb) ? 1 : 0;
            4'd8:  r.lo = (av < bv) ? 1 : 0;
            4'd9:  r.lo = av << sh;
            4'd10: r.lo = av >> sh;
            4'd11: r.lo = W'(sa >>> sh);
            4'd12: begin prod = {32'd0, av} * {32'd0, bv}; r.lo = prod[31:0]; r.hi = prod[63:32]; end
            4'd13: begin
                if (bv == 0) begin r.lo = '1; r.hi = av; r.dz = 1'b1; end
                else begin r.lo = av / bv; r.hi = av % bv; end
            end
            default: r.il = 1'b1;
        endcase
        r.z = (r.lo == 0);
        return r;
    endfunction

    // Issue one operation; returns latency (0 = no done within budget) and outputs at done
    task automatic exec(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int poke_at, output int lat, output logic rdy_at_done, output res_t obs);
        @(negedge clk);
        start = 1'b1; alu_control = op; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; alu_control = 4'($urandom); a = $urandom; b = $urandom;
        lat = 0; rdy_at_done = 1'bx; obs = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start = (i == poke_at);
            if (done) begin
                lat = i;
                rdy_at_done = ready;
                obs = {alu_out, hi_out, zout, ovf, div_by_zero, illegal};
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; alu_control = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ready, done, alu_out, hi_out, zout, ovf, div_by_zero, illegal} !== {2'b10, 64'd0, 4'b1000}) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b done=%b out=%h hi=%h z=%b ov=%b dz=%b il=%b, expected 1 0 0 0 1 0 0 0",
                     ready, done, alu_out, hi_out, zout, ovf, div_by_zero, illegal);
        end
    endtask

    task automatic test_add_overflow;
        int lat; logic rdy; res_t obs; res_t exp;
        exp = mk(32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        exec(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, lat, rdy, obs);
        n_checks++;
        if (lat !== 1) begin n_errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
        n_checks++;
        if (rdy !== 1'b0) begin n_errors++; $display("FAIL add_ready_in_done: got %b expected 0", rdy); end
        n_checks++;
        if (obs !== exp) begin n_errors++; $display("FAIL add_ovf_result: got %h expected %h", obs, exp); end
        @(negedge clk);
        n_checks++;
        if ({ready, done} !== 2'b10) begin n_errors++; $display("FAIL add_after_done: got rdy/done=%b expected 10", {ready, done}); end
    endtask

    task automatic test_compare_shift;
        vec_t v[6];
        int lat; logic rdy; res_t obs;
        v[0] = '{OP_SLT,  32'h8000_0000, 32'h1,  mk(32'h1, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
        v[1] = '{OP_SLTU, 32'h8000_0000, 32'h1,  mk(32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0)};
        v[2] = '{OP_SUB,  32'h5,         32'h5,  mk(32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0)};
        v[3] = '{OP_SRA,  32'hF000_0000, 32'h4,  mk(32'hFF00_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
        v[4] = '{OP_SRL,  32'hF000_0000, 32'h4,  mk(32'h0F00_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
        v[5] = '{OP_SLL,  32'h1,         32'h21, mk(32'h2, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
        for (int i = 0; i < 6; i++) begin
            exec(v[i].op, v[i].av, v[i].bv, 0, lat, rdy, obs);
            n_checks++;
            if (obs !== v[i].exp || lat !== 1) begin
                n_errors++;
                $display("FAIL cmp_shift[%0d] op=%h: got %h lat=%0d expected %h lat=1", i, v[i].op, obs, lat, v[i].exp);
            end
        end
    endtask

    task automatic test_multu;
        int lat; logic rdy; res_t obs; res_t exp; logic extra;
        exp = mk(32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        exec(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, lat, rdy, obs);
        n_checks++;
        if (lat !== 33) begin n_errors++; $display("FAIL multu_latency: got %0d expected 33", lat); end
        n_checks++;
        if (obs !== exp) begin n_errors++; $display("FAIL multu_result: got %h expected %h", obs, exp); end
        extra = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) extra = 1'b1;
        end
        n_checks++;
        if (extra !== 1'b0 || alu_out !== 32'h1) begin
            n_errors++;
            $display("FAIL multu_ignored_start: got extra_done=%b out=%h expected 0 00000001", extra, alu_out);
        end
    endtask

    task automatic test_divu;
        vec_t v[2];
        int lat; logic rdy; res_t obs;
        v[0] = '{OP_DIVU, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0)};
        v[1] = '{OP_DIVU, 32'd9,   32'd0, mk(32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b1, 1'b0)};
        for (int i = 0; i < 2; i++) begin
            exec(v[i].op, v[i].av, v[i].bv, 0, lat, rdy, obs);
            n_checks++;
            if (obs !== v[i].exp || lat !== 33) begin
                n_errors++;
                $display("FAIL divu[%0d]: got %h lat=%0d expected %h lat=33", i, obs, lat, v[i].exp);
            end
        end
    endtask

    task automatic test_async_reset_illegal;
        int lat; logic rdy; res_t obs; res_t exp; logic seen;
        exec(OP_ADD, 32'd3, 32'd4, 0, lat, rdy, obs);
        @(negedge clk);
        start = 1'b1; alu_control = OP_MULTU; a = $urandom; b = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({ready, done, alu_out, hi_out, zout, ovf, div_by_zero, illegal} !== {2'b10, 64'd0, 4'b1000}) begin
            n_errors++;
            $display("FAIL async_reset: got rdy=%b done=%b out=%h hi=%h z=%b expected 1 0 0 0 1",
                     ready, done, alu_out, hi_out, zout);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_errors++; $display("FAIL reset_no_done: got done pulse=%b expected 0", seen); end
        exp = mk(32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        exec(4'b0100, 32'h1234_5678, 32'h9ABC_DEF0, 0, lat, rdy, obs);
        n_checks++;
        if (obs !== exp || lat !== 1) begin
            n_errors++;
            $display("FAIL illegal_op: got %h lat=%0d expected %h lat=1", obs, lat, exp);
        end
    endtask

    task automatic test_back_to_back;
        int dones;
        dones = 0;
        @(negedge clk);
        start = 1'b1; alu_control = OP_ADD; a = 32'd1; b = 32'd2;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        n_checks++;
        if (dones !== 10 || alu_out !== 32'd3) begin
            n_errors++;
            $display("FAIL back_to_back: got dones=%0d out=%h expected 10 00000003", dones, alu_out);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat; logic rdy; res_t obs; res_t exp;
        logic [3:0] op; logic [W-1:0] av; logic [W-1:0] bv; int exp_lat;
        for (int i = 0; i < 50; i++) begin
            op = 4'($urandom_range(0, 15));
            av = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : $urandom;
            bv = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : $urandom;
            exp = model(op, av, bv);
            exp_lat = (op == OP_MULTU || op == OP_DIVU) ? 33 : 1;
            exec(op, av, bv, 0, lat, rdy, obs);
            n_checks++;
            if (obs !== exp || lat !== exp_lat || rdy !== 1'b0) begin
                n_errors++;
                $display("FAIL random[%0d] op=%h a=%h b=%h: got %h lat=%0d rdy=%b expected %h lat=%0d rdy=0",
                         i, op, av, bv, obs, lat, rdy, exp, exp_lat);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_compare_shift();
        test_multu();
        test_divu();
        test_async_reset_illegal();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the datapath's single-cycle combinational ALU.
- Adds the following over the single-cycle unit:
  - width parameter
  - shifts and unsigned set-less-than
  - correct signed SLT
  - overflow flag
  - iterative unsigned multiply/divide with HI/LO results
  - start/ready/done handshake
- Sits in the EX stage; the control unit stalls the pipeline while ready is low.

Parameters:
- WIDTH, 32, operand/result width (>=8, power of two).
- SHW, $clog2(WIDTH), shift-amount bits taken from b.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- alu_control  input  4  operation code, sampled on accepted start
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse; results valid from this cycle
- alu_out  output  WIDTH  result (LO for MULTU/DIVU)
- hi_out  output  WIDTH  MULTU upper half / DIVU remainder; 0 for other ops
- zout  output  1  alu_out == 0
- ovf  output  1  signed overflow (ADD/SUB only, else 0)
- div_by_zero  output  1  DIVU with b==0
- illegal  output  1  unsupported alu_control

Behaviour:
- Reset (asynchronous, any state):
  - state IDLE; ready=1, done=0.
  - alu_out=0, hi_out=0, zout=1, ovf=0, div_by_zero=0, illegal=0.
  - In-flight operation is discarded; no done is produced.
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0101 NOR
  - 0110 SUB (a-b)
  - 0111 SLT signed (true signed compare, correct on overflow)
  - 1000 SLTU
  - 1001 SLL
  - 1010 SRL
  - 1011 SRA; shift operand is a, amount is b[SHW-1:0]
  - 1100 MULTU ({hi,lo}=a*b, unsigned)
  - 1101 DIVU (lo=a/b, hi=a%b)
  - All others: illegal=1, alu_out=0, hi_out=0.
- Arithmetic is modulo 2^WIDTH.
- ovf: set when operand signs agree and result sign differs (ADD); same rule with ~b (SUB).
- SLT/SLTU produce 0 or 1 in bit 0.
- State machine: IDLE, MUL, DIV, DONE.
  - IDLE + start, single-cycle op or illegal: register results, go to DONE.
  - IDLE + start, MULTU: load multiplicand/multiplier, clear product, counter=WIDTH, go to MUL.
  - IDLE + start, DIVU: load dividend, divisor, remainder=0, counter=WIDTH, go to DIV.
  - MUL: one shift-add step per cycle; when counter reaches 0, write {hi_out, alu_out} and go to DONE.
  - DIV: one restoring-division step per cycle; when counter reaches 0, write results and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency, start-accept edge to done-high cycle:
  - 1 cycle for single-cycle and illegal ops.
  - WIDTH+1 cycles for MULTU/DIVU.
- ready is combinational from state (IDLE only).
  - start while ready=0 is ignored, including during the DONE cycle.
  - Back-to-back throughput: one single-cycle op every 2 cycles.
- Divide by zero:
  - Full WIDTH+1 latency is kept.
  - alu_out = all ones, hi_out = a, div_by_zero=1.
- Flag updates:
  - zout, ovf, div_by_zero and illegal update together with alu_out.
  - All outputs hold until the next operation's completion.
  - Flags not applicable to the completing op are cleared.
- Operands are captured at accept; later changes to a/b/alu_control do not affect the operation in flight.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_AND … OP_DIVU)
  - FSM state enum (S_IDLE, S_MUL, S_DIV, S_DONE)
- Sub-module alu_iter_muldiv holds the iterative engine:
  - ports: clk, reset, go, is_div, a, b, busy, fin, hi, lo
  - contains the counter, shift registers and subtract/compare logic
- Top level keeps the FSM, the combinational single-cycle ops and the output registers.

Test Plan:
- ADD 0x7FFFFFFF+1, start at cycle 0 -> done in cycle 1; alu_out=0x80000000, ovf=1, zout=0; ready=0 in cycle 1, 1 in cycle 2.
- SLT a=0x80000000, b=0x00000001 -> alu_out=1. SLTU with same operands -> alu_out=0. SUB 5-5 -> alu_out=0, zout=1.
- SRA a=0xF0000000, b=4 -> alu_out=0xFF000000. SRL with same operands -> 0x0F000000. SLL a=1, b=0x21 -> alu_out=2 (only 5 bits used).
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 33 cycles after accept; hi_out=0xFFFFFFFE, alu_out=0x00000001. A second start pulsed mid-operation is ignored.
- DIVU 100/7 -> alu_out=14, hi_out=2, latency 33. DIVU 9/0 -> alu_out=0xFFFFFFFF, hi_out=9, div_by_zero=1.
- Reset asserted asynchronously in cycle 10 of a MULTU -> immediately ready=1, alu_out=0, zout=1, no done pulse. Opcode 0100 afterwards -> illegal=1, alu_out=0, done after 1 cycle.
